// File: rtl/timer_sched.sv
// Round-robin scheduler time-sharing one down-counter among NREQ delay requesters.
// Latency: ack 1 cycle after a sampled request, done D+1 cycles after ack; i_en low freezes the count.
// Backpressure: requests are level-held until ack; at most one delay runs at a time.
module timer_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*WIDTH-1:0]   i_delay,
    output logic [NREQ-1:0]         o_ack,
    output logic [NREQ-1:0]         o_done,
    output logic                    o_busy,
    output logic [$clog2(NREQ)-1:0] o_owner
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t           state = IDLE;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt = '0;
    logic [WIDTH-1:0] cnt_nxt;
    logic [PW-1:0]    ptr = '0;
    logic [PW-1:0]    ptr_nxt;
    logic [PW-1:0]    owner = '0;
    logic [PW-1:0]    owner_nxt;
    logic [NREQ-1:0]  ack = '0;
    logic [NREQ-1:0]  ack_nxt;
    logic [NREQ-1:0]  done = '0;
    logic [NREQ-1:0]  done_nxt;
    logic             busy = 1'b0;
    logic             busy_nxt;

    logic [WIDTH-1:0] dly [NREQ];
    logic [PW-1:0]    win;
    logic             found;
    logic [PW:0]      idx;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            dly[i] = i_delay[i*WIDTH +: WIDTH];
        end
    end

    // First set request at or above ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (!found && i_req[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        ack_nxt   = '0;
        done_nxt  = '0;
        case (state)
            IDLE: begin
                if (i_en && found) begin
                    cnt_nxt   = dly[win];
                    owner_nxt = win;
                    ack_nxt   = NREQ'(1) << win;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (i_en) begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - WIDTH'(1);
                    end else begin
                        done_nxt  = NREQ'(1) << owner;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                ptr_nxt   = (owner == PW'(NREQ-1)) ? '0 : owner + PW'(1);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            owner <= '0;
            ack   <= '0;
            done  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            ack   <= ack_nxt;
            done  <= done_nxt;
            busy  <= busy_nxt;
        end
    end

    assign o_ack   = ack;
    assign o_done  = done;
    assign o_busy  = busy;
    assign o_owner = owner;
endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched (NREQ=4, WIDTH=4) with per-cycle invariant monitor.
module tb_timer_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  en  = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] delay = '0;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [1:0]            owner;

    int n_tests = 0;
    int n_fail  = 0;

    timer_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_req   (req),
        .i_delay (delay),
        .o_ack   (ack),
        .o_done  (done),
        .o_busy  (busy),
        .o_owner (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_delay(input int k, input logic [WIDTH-1:0] d);
        delay[k*WIDTH +: WIDTH] = d;
    endtask

    // Request k alone, then count cycles from its ack to its done.
    task automatic measure(input int k, input logic [WIDTH-1:0] d, input int exp, input string tag);
        int n;
        set_delay(k, d);
        req = NREQ'(1) << k;
        for (int w = 0; w < 6; w++) begin
            step();
            if (ack != '0) break;
        end
        chk({tag, "_ack"}, ack, NREQ'(1) << k);
        req = '0;
        n = 0;
        for (int w = 0; w < 40; w++) begin
            step();
            n++;
            if (done != '0) break;
        end
        chk({tag, "_lat"}, n, exp);
        step();
        step();
    endtask

    logic [NREQ-1:0] last_ack = '0;
    always @(negedge clk) begin
        chk("inv_ack_onehot0", $onehot0(ack), 1);
        chk("inv_done_onehot0", $onehot0(done), 1);
        chk("inv_ack_done_excl", (ack != '0) && (done != '0), 0);
        if (done != '0) chk("inv_done_follows_ack", done, last_ack);
        if (ack != '0) last_ack = ack;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] exp_ack;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_ack", ack, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        rst = 1'b0;

        // Single request, delay 5: ack cycle 1, done cycle 7, busy 1..7
        en  = 1'b1;
        req = 4'b0001;
        set_delay(0, 5);
        step();
        chk("single_ack", ack, 4'b0001);
        chk("single_busy1", busy, 1);
        chk("single_owner", owner, 0);
        req = '0;
        for (int c = 2; c <= 6; c++) begin
            step();
            chk("single_nodone", done, 0);
            chk("single_busy", busy, 1);
        end
        step();
        chk("single_done", done, 4'b0001);
        chk("single_busy7", busy, 1);
        step();
        chk("single_done_clr", done, 0);
        chk("single_idle", busy, 0);
        chk("single_owner_hold", owner, 0);

        // Contention, all delays 0: owners 0,1,2,3,0 every 3 cycles
        rst = 1'b1;
        step();
        rst   = 1'b0;
        delay = '0;
        req   = 4'b1111;
        for (int c = 1; c <= 13; c++) begin
            step();
            exp_ack = (c % 3 == 1) ? (NREQ'(1) << (((c - 1) / 3) % 4)) : '0;
            chk("rr_ack", ack, exp_ack);
        end
        req = '0;
        step();
        step();
        step();
        chk("rr_idle", busy, 0);

        // Pause: delay 4, en low 3 cycles mid-count -> done at cycle 9 instead of 6
        req = 4'b0010;
        set_delay(1, 4);
        step();
        chk("pause_ack", ack, 4'b0010);
        req = '0;
        step();
        chk("pause_nodone2", done, 0);
        en = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            step();
            chk("pause_frozen_nodone", done, 0);
            chk("pause_frozen_busy", busy, 1);
        end
        en = 1'b1;
        for (int c = 6; c <= 8; c++) begin
            step();
            chk("pause_nodone", done, 0);
        end
        step();
        chk("pause_done", done, 4'b0010);
        step();
        chk("pause_idle", busy, 0);

        // en low in IDLE: no grant, owner holds
        en  = 1'b0;
        req = 4'b0100;
        set_delay(2, 10);
        step();
        step();
        chk("en_off_ack", ack, 0);
        chk("en_off_busy", busy, 0);
        chk("en_off_owner", owner, 1);

        // Reset 2 cycles after ack for requester 2, then 0110 -> winner 1
        en = 1'b1;
        step();
        chk("rst_mid_ack", ack, 4'b0100);
        chk("rst_mid_owner", owner, 2);
        step();
        step();
        rst = 1'b1;
        req = 4'b0110;
        step();
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_owner0", owner, 0);
        step();
        chk("post_rst_ack", ack, 4'b0010);
        chk("post_rst_owner", owner, 1);
        req = '0;
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("post_rst_nodone", done, 0);
        end
        step();
        chk("post_rst_done", done, 4'b0010);
        step();

        // Boundaries: full-scale delay and zero delay
        measure(3, 4'hF, 16, "max_delay");
        measure(0, 4'h0, 1, "zero_delay");

        // Re-eligibility: ptr=1, 0011 held -> 1, 0, 1
        set_delay(0, 0);
        set_delay(1, 0);
        req = 4'b0011;
        for (int c = 1; c <= 7; c++) begin
            step();
            exp_ack = (c == 1 || c == 7) ? 4'b0010 : ((c == 4) ? 4'b0001 : 4'b0000);
            chk("reelig_ack", ack, exp_ack);
        end
        req = '0;
        step();
        step();
        step();
        chk("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 Parameters SHALL be:
- NREQ, default 4, number of requesters (2..8).
- WIDTH, default 16, delay/counter width in bits.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- i_clk, input, 1, single clock; all logic on its rising edge.
- i_rst, input, 1, synchronous active-high reset.
- i_en, input, 1, global count enable; low freezes counting and grants.
- i_req, input, NREQ, per-requester level request; held until o_ack.
- i_delay, input, NREQ*WIDTH, per-requester delay; slice k = bits [k*WIDTH +: WIDTH].
- o_ack, output, NREQ, one-hot one-cycle pulse: request accepted, delay latched.
- o_done, output, NREQ, one-hot one-cycle pulse: owner's delay expired.
- o_busy, output, 1, high while the shared counter is owned (COUNT or DONE).
- o_owner, output, $clog2(NREQ), index of current/last owner.

REQ-003 All outputs SHALL be registered; no combinational path from inputs to outputs.

Function
REQ-004 The block SHALL own one shared WIDTH-bit down-counter, time-shared among requesters; only one delay runs at a time.

REQ-005 The FSM SHALL have exactly three states: IDLE, COUNT, DONE.

REQ-006 IDLE behaviour at each edge with i_en=1 and i_req!=0:
- Select the winner by round-robin: first set bit of i_req scanning upward from pointer ptr, wrapping at NREQ-1 -> 0.
- Load counter <= i_delay[winner].
- o_owner <= winner; o_ack[winner] <= 1.
- State -> COUNT.

REQ-007 IDLE SHALL take no action if i_en=0 or i_req=0.

REQ-008 COUNT behaviour with i_en=1:
- Counter != 0: decrement by 1.
- Counter == 0: o_done[o_owner] <= 1; state -> DONE.

REQ-009 COUNT with i_en=0 SHALL hold the counter and state unchanged.

REQ-010 DONE behaviour at the next edge, regardless of i_en:
- ptr <= (o_owner+1) mod NREQ.
- State -> IDLE.

REQ-011 o_ack and o_done SHALL each be high for exactly one cycle per grant.

REQ-012 Latency with i_en held high:
- o_ack rises 1 cycle after the sampling edge.
- o_done rises D+1 cycles after o_ack, for delay D.
- The next grant can be sampled in the cycle o_done is low again.
- Minimum grant-to-grant spacing is D+3 cycles.

REQ-013 Delay 0 SHALL be legal: o_done rises 1 cycle after o_ack.

REQ-014 Delay 2^WIDTH-1 SHALL count fully without wrap: 2^WIDTH cycles from o_ack to o_done.

REQ-015 i_req changes while in COUNT/DONE SHALL be ignored; there is no cancellation. Deasserting the owner's i_req does not stop its delay.

REQ-016 A requester still asserting i_req after its o_done SHALL be re-eligible. Because ptr has advanced past it, any other pending requester wins first.

REQ-017 o_busy SHALL be high in COUNT and DONE, low in IDLE.

REQ-018 o_owner SHALL hold its value in IDLE until the next grant.

Reset
REQ-019 With i_rst=1 at an edge, the block SHALL set:
- state=IDLE, counter=0, ptr=0, o_owner=0.
- o_ack=0, o_done=0, o_busy=0.
- Reset overrides all other inputs.

REQ-020 Reset mid-COUNT or mid-DONE SHALL abandon the grant with no o_done pulse. The next grant after reset starts scanning from requester 0.

REQ-021 The power-up register state SHALL equal the reset state.

Verification
REQ-022 Single request: i_req=0001, i_delay[0]=5, i_en=1 -> o_ack=0001 at cycle 1, o_done=0001 at cycle 7, o_busy high cycles 1-7.

REQ-023 Contention: i_req=1111 held, all delays=0 -> o_ack order 0,1,2,3,0, one grant every 3 cycles.

REQ-024 Pause: delay=4, i_en low for 3 cycles mid-COUNT -> o_done delayed by exactly 3 cycles versus REQ-022 timing.

REQ-025 Reset mid-operation: i_rst pulsed 2 cycles after o_ack for requester 2 -> no o_done. Then i_req=0110 -> winner is 1.

REQ-026 Boundary: WIDTH=4, delay=15 -> o_done 16 cycles after o_ack. Delay=0 -> o_done 1 cycle after o_ack.

REQ-027 Invariants checked every cycle:
- o_ack and o_done each one-hot or zero.
- Never both nonzero in the same cycle.
- o_done[k] only follows o_ack[k].
